// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-stream packet arbiters.
package axis_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // Index width that never collapses to zero bits for a single requester.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from last+1, modulo NUM.
module axis_rr_pick
  import axis_arb_pkg::*;
#(
  parameter int NUM = 4,
  parameter int IW  = clog2_min1(NUM)
) (
  input  logic [NUM-1:0] req,
  input  logic [IW-1:0]  last,
  output logic [IW-1:0]  gnt_idx,
  output logic           any
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 1; k <= NUM; k++) begin
      logic [IW-1:0] w_idx;
      w_idx = IW'((int'(last) + k) % NUM);
      if (!any && req[w_idx]) begin
        gnt_idx = w_idx;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_packet_rr_arbiter.sv
// Packet-granular round-robin arbiter of NUM AXI-stream sources onto one packet FIFO.
// Optional over-length guard (truncate + drain) enabled by `define AXIS_ARB_LEN_GUARD_EN.
module axis_packet_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM       = 4,
  parameter int DSIZE     = 32,
  parameter int MAX_BEATS = 4096,
  parameter int IW        = clog2_min1(NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM-1:0]       s_tvalid,
  output logic [NUM-1:0]       s_tready,
  input  logic [NUM*DSIZE-1:0] s_tdata,
  input  logic [NUM-1:0]       s_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [DSIZE-1:0]     m_tdata,
  output logic                 m_tlast,
  output logic [IW-1:0]        m_tid,
  output logic [NUM-1:0]       grant_vec,
  output logic [15:0]          pkt_cnt,
  output logic                 trunc_err
);

  if (NUM < 2 || NUM > 16 || MAX_BEATS < 2 || MAX_BEATS > 65536) begin : g_bad_params
    $error("axis_packet_rr_arbiter: NUM or MAX_BEATS out of range");
  end

  arb_state_t       r_state;
  logic [NUM-1:0]   r_grant_vec;
  logic [IW-1:0]    r_tid;
  logic [IW-1:0]    r_last_grant;
  logic [15:0]      r_pkt_cnt;
  logic [15:0]      r_beat_cnt;
  logic             r_trunc_err;

  logic [IW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic [DSIZE-1:0] w_src_data [NUM];
  logic             w_xfer;
  logic             w_hs;
  logic             w_eop;
  logic             w_force;

  axis_rr_pick #(.NUM(NUM), .IW(IW)) u_pick (
    .req     (s_tvalid),
    .last    (r_last_grant),
    .gnt_idx (w_pick_idx),
    .any     (w_pick_any)
  );

  always_comb begin
    for (int i = 0; i < NUM; i++) w_src_data[i] = s_tdata[i*DSIZE +: DSIZE];
  end

  assign w_xfer = (r_state == XFER);

`ifdef AXIS_ARB_LEN_GUARD_EN
  // Last beat the FIFO can accept for this packet: force tlast if the source did not.
  assign w_force = w_xfer && (r_beat_cnt == 16'(MAX_BEATS - 1)) && !s_tlast[r_tid];
`else
  assign w_force = 1'b0;
`endif

  assign m_tvalid  = w_xfer && s_tvalid[r_tid];
  assign m_tdata   = w_src_data[r_tid];
  assign m_tlast   = w_xfer && (s_tlast[r_tid] || w_force);
  assign m_tid     = r_tid;
  assign grant_vec = r_grant_vec;
  assign pkt_cnt   = r_pkt_cnt;
  assign trunc_err = r_trunc_err;
  assign w_hs      = m_tvalid && m_tready;
  assign w_eop     = w_hs && m_tlast;

  always_comb begin
    s_tready = '0;
    if (w_xfer) s_tready[r_tid] = m_tready;
`ifdef AXIS_ARB_LEN_GUARD_EN
    else if (r_state == DRAIN) s_tready[r_tid] = 1'b1;
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: reset is asynchronous, so a mid-packet reset drops the grant without waiting for an edge.
    if (rst) begin
      r_state      <= IDLE;
      r_grant_vec  <= '0;
      r_tid        <= '0;
      r_last_grant <= IW'(NUM - 1);
      r_pkt_cnt    <= '0;
      r_beat_cnt   <= '0;
      r_trunc_err  <= 1'b0;
    end else begin
      r_trunc_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_grant_vec <= NUM'(1) << w_pick_idx;
            r_tid       <= w_pick_idx;
            r_state     <= XFER;
          end
        end
        XFER: begin
          if (w_eop) begin
            r_last_grant <= r_tid;
            r_beat_cnt   <= '0;
            r_pkt_cnt    <= r_pkt_cnt + 16'd1;
            r_grant_vec  <= '0;
`ifdef AXIS_ARB_LEN_GUARD_EN
            r_trunc_err  <= w_force;
            r_state      <= w_force ? DRAIN : IDLE;
`else
            r_state      <= IDLE;
`endif
          end else if (w_hs && r_beat_cnt != 16'hFFFF) begin
            r_beat_cnt <= r_beat_cnt + 16'd1;
          end
        end
`ifdef AXIS_ARB_LEN_GUARD_EN
        DRAIN: begin
          if (s_tvalid[r_tid] && s_tlast[r_tid]) r_state <= IDLE;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_rr_arbiter.sv
// Directed self-checking bench for axis_packet_rr_arbiter (NUM=4, DSIZE=32, MAX_BEATS=8).
module tb_axis_packet_rr_arbiter;

  localparam int NUM       = 4;
  localparam int DSIZE     = 32;
  localparam int MAX_BEATS = 8;
  localparam int IW        = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM-1:0]       s_tvalid, s_tready, s_tlast, grant_vec;
  logic [NUM*DSIZE-1:0] s_tdata;
  logic                 m_tvalid, m_tready, m_tlast, trunc_err;
  logic [DSIZE-1:0]     m_tdata;
  logic [IW-1:0]        m_tid;
  logic [15:0]          pkt_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  axis_packet_rr_arbiter #(.NUM(NUM), .DSIZE(DSIZE), .MAX_BEATS(MAX_BEATS)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .s_tlast   (s_tlast),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .m_tid     (m_tid),
    .grant_vec (grant_vec),
    .pkt_cnt   (pkt_cnt),
    .trunc_err (trunc_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int i, input logic v, input logic l, input logic [DSIZE-1:0] d);
    s_tvalid[i]                = v;
    s_tlast[i]                 = l;
    s_tdata[i*DSIZE +: DSIZE]  = d;
  endtask

  typedef struct {
    logic [NUM-1:0] req;
    logic [IW-1:0]  tid;
    logic [NUM-1:0] gvec;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int beat;
    int bt [NUM];
    int exp_seq [5];
    int npk;
    logic prev_eop;
    logic [NUM-1:0] hs_vec;

    // Single-beat packets; expected winner hand-derived from the previous winner.
    tbl[0] = '{4'b0100, 2'd2, 4'b0100};  // last=2 after the 3-beat packet
    tbl[1] = '{4'b1111, 2'd3, 4'b1000};
    tbl[2] = '{4'b1111, 2'd0, 4'b0001};
    tbl[3] = '{4'b0011, 2'd1, 4'b0010};
    tbl[4] = '{4'b0001, 2'd0, 4'b0001};
    tbl[5] = '{4'b1010, 2'd1, 4'b0010};
    tbl[6] = '{4'b1010, 2'd3, 4'b1000};
    tbl[7] = '{4'b0110, 2'd1, 4'b0010};
    tbl[8] = '{4'b1000, 2'd3, 4'b1000};
    tbl[9] = '{4'b0101, 2'd0, 4'b0001};
    exp_seq = '{0, 1, 2, 3, 0};

    rst = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst grant_vec", grant_vec, 0);
    check("rst m_tvalid", m_tvalid, 0);
    check("rst s_tready", s_tready, 0);
    check("rst pkt_cnt", pkt_cnt, 0);
    check("rst m_tid", m_tid, 0);
    check("rst trunc_err", trunc_err, 0);
    rst = 1'b0;

    // Single source 2, three beats.
    drive(2, 1'b1, 1'b0, 32'h2000); m_tready = 1'b1;
    #1 check("s2 no grant yet", grant_vec, 0);
    for (int b = 0; b < 3; b++) begin
      @(posedge clk); @(negedge clk);
      drive(2, 1'b1, b == 2, 32'h2000 + b);
      #1;
      check($sformatf("s2 b%0d grant", b), grant_vec, 4'b0100);
      check($sformatf("s2 b%0d tid", b), m_tid, 2);
      check($sformatf("s2 b%0d data", b), m_tdata, 32'h2000 + b);
      check($sformatf("s2 b%0d last", b), m_tlast, b == 2);
      check($sformatf("s2 b%0d ready", b), s_tready, 4'b0100);
    end
    @(posedge clk); @(negedge clk);
    s_tvalid = '0;
    check("s2 pkt_cnt", pkt_cnt, 1);
    check("s2 idle grant", grant_vec, 0);
    check("s2 idle valid", m_tvalid, 0);

    // Table-driven arbitration order.
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < NUM; i++) drive(i, tbl[k].req[i], 1'b1, 32'hA000_0000 + i);
      @(posedge clk); @(negedge clk);
      check($sformatf("tbl%0d grant", k), grant_vec, tbl[k].gvec);
      check($sformatf("tbl%0d tid", k), m_tid, tbl[k].tid);
      check($sformatf("tbl%0d data", k), m_tdata, 32'hA000_0000 + tbl[k].tid);
      check($sformatf("tbl%0d ready", k), s_tready, tbl[k].gvec);
      @(posedge clk); @(negedge clk);
      s_tvalid = '0;
      check($sformatf("tbl%0d pkt_cnt", k), pkt_cnt, 2 + k);
      check($sformatf("tbl%0d idle", k), grant_vec, 0);
    end

    // Backpressure on a 4-beat packet from source 1.
    drive(1, 1'b1, 1'b0, 32'hB0); m_tready = 1'b0;
    @(posedge clk); @(negedge clk);
    beat = 0;
    for (int c = 0; c < 20 && beat < 4; c++) begin
      m_tready = (c % 2 == 0);
      #1;
      check("bp grant", grant_vec, 4'b0010);
      check("bp ready", s_tready, m_tready ? 4'b0010 : 4'b0000);
      check("bp data", m_tdata, 32'hB0 + beat);
      check("bp last", m_tlast, beat == 3);
      @(posedge clk);
      if (m_tready) beat++;
      @(negedge clk);
      if (beat < 4) drive(1, 1'b1, beat == 3, 32'hB0 + beat);
      else s_tvalid[1] = 1'b0;
    end
    check("bp beats", beat, 4);
    check("bp pkt_cnt", pkt_cnt, 12);
    m_tready = 1'b1;

    // Source 3 stalls mid-packet while source 0 waits.
    drive(3, 1'b1, 1'b0, 32'hC0);
    @(posedge clk); @(negedge clk);
    check("stall grant3", grant_vec, 4'b1000);
    drive(0, 1'b1, 1'b1, 32'hD0);
    @(posedge clk); @(negedge clk);
    drive(3, 1'b1, 1'b0, 32'hC1);
    @(posedge clk); @(negedge clk);
    s_tvalid[3] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall held grant", grant_vec, 4'b1000);
      check("stall ready", s_tready, 4'b1000);
      check("stall no valid", m_tvalid, 0);
      @(posedge clk); @(negedge clk);
    end
    drive(3, 1'b1, 1'b0, 32'hC2);
    #1 check("stall resume data", m_tdata, 32'hC2);
    @(posedge clk); @(negedge clk);
    drive(3, 1'b1, 1'b1, 32'hC3);
    #1 check("stall tlast", m_tlast, 1);
    @(posedge clk); @(negedge clk);
    s_tvalid[3] = 1'b0;
    check("stall released", grant_vec, 0);
    @(posedge clk); @(negedge clk);
    check("stall then src0", grant_vec, 4'b0001);
    check("stall src0 data", m_tdata, 32'hD0);
    @(posedge clk); @(negedge clk);
    s_tvalid = '0;
    check("stall pkt_cnt", pkt_cnt, 14);

    // Async reset on beat 2 of a 4-beat packet.
    drive(2, 1'b1, 1'b0, 32'hE0);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    drive(2, 1'b1, 1'b0, 32'hE1);
    #2 rst = 1'b1;
    #1;
    check("arst grant", grant_vec, 0);
    check("arst valid", m_tvalid, 0);
    check("arst pkt_cnt", pkt_cnt, 0);
    check("arst ready", s_tready, 0);
    @(negedge clk);
    rst = 1'b0; s_tvalid = '0;

    // Contention: all sources offer 2-beat packets continuously.
    for (int i = 0; i < NUM; i++) begin
      bt[i] = 0;
      drive(i, 1'b1, 1'b0, 32'hF000 + i * 16);
    end
    npk = 0; prev_eop = 1'b0;
    for (int c = 0; c < 40 && npk < 5; c++) begin
      #1;
      if (prev_eop) check("ctn bubble", m_tvalid, 0);
      hs_vec = s_tvalid & s_tready;
      prev_eop = m_tvalid && m_tready && m_tlast;
      if (m_tvalid && m_tready) begin
        check($sformatf("ctn p%0d tid", npk), m_tid, exp_seq[npk]);
        check($sformatf("ctn p%0d ready", npk), s_tready, 1 << exp_seq[npk]);
        check($sformatf("ctn p%0d data", npk), m_tdata, 32'hF000 + exp_seq[npk] * 16 + bt[exp_seq[npk]]);
        if (m_tlast) npk++;
      end
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < NUM; i++) if (hs_vec[i]) bt[i] = (bt[i] + 1) % 2;
      if (npk >= 5) s_tvalid = '0;
      else for (int i = 0; i < NUM; i++) drive(i, 1'b1, bt[i] == 1, 32'hF000 + i * 16 + bt[i]);
    end
    check("ctn packets", npk, 5);
    check("ctn pkt_cnt", pkt_cnt, 5);

`ifdef AXIS_ARB_LEN_GUARD_EN
    begin : guard
      int out_beats;
      int src_beat;
      int n_trunc;
      logic hs;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      out_beats = 0; src_beat = 0; n_trunc = 0;
      drive(0, 1'b1, 1'b0, 32'h100);
      for (int c = 0; c < 40 && src_beat < 12; c++) begin
        #1;
        if (m_tvalid && m_tready) begin
          out_beats++;
          check($sformatf("guard out%0d last", out_beats), m_tlast, out_beats == 8);
        end
        if (trunc_err) begin
          n_trunc++;
          check("guard trunc timing", out_beats, 8);
        end
        if (src_beat >= 8) check("guard drain valid", m_tvalid, 0);
        hs = s_tvalid[0] && s_tready[0];
        @(posedge clk); @(negedge clk);
        if (hs) src_beat++;
        if (src_beat < 12) drive(0, 1'b1, src_beat == 11, 32'h100 + src_beat);
        else s_tvalid[0] = 1'b0;
      end
      check("guard src beats", src_beat, 12);
      check("guard out beats", out_beats, 8);
      check("guard trunc pulses", n_trunc, 1);
      check("guard pkt_cnt", pkt_cnt, 1);
      @(posedge clk); @(negedge clk);
      check("guard idle grant", grant_vec, 0);
      check("guard idle ready", s_tready, 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
